// File: rtl/ram_rr_arbiter.sv
// Two-requester single-port RAM arbiter with round-robin tie-break.
// After reset, and on each clear request, the whole memory is zeroed.
module ram_rr_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] q_b,
  output logic              qv_a,
  output logic              qv_b,
  output logic              busy
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_ptr;   // 0 = A has priority, 1 = B
  logic [DATA_W-1:0] r_ram [2**ADDR_W];

  logic              w_run;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;

  assign busy  = (r_state == CLEAR);
  assign w_run = (r_state == RUN) && !rst && !clr_start;
  assign gnt_a = w_run && req_a && (!req_b || !r_ptr);
  assign gnt_b = w_run && req_b && (!req_a ||  r_ptr);

  // Single RAM port shared by the clear sweep and the granted requester.
  always_comb begin
    w_we    = 1'b0;
    w_addr  = r_cnt;
    w_wdata = '0;
    if (!rst && r_state == CLEAR) begin
      w_we = 1'b1;
    end else if (gnt_a) begin
      w_addr  = addr_a;
      w_wdata = data_a;
      w_we    = we_a;
    end else if (gnt_b) begin
      w_addr  = addr_b;
      w_wdata = data_b;
      w_we    = we_b;
    end
  end

  assign w_rdata = r_ram[w_addr];

  always_ff @(posedge clk) begin
    if (w_we) r_ram[w_addr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ptr   <= 1'b0;
      q_a     <= '0;
      q_b     <= '0;
      qv_a    <= 1'b0;
      qv_b    <= 1'b0;
    end else begin
      qv_a <= 1'b0;
      qv_b <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) r_state <= RUN;
        end
        RUN: begin
          if (clr_start) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
          end else if (gnt_a) begin
            r_ptr <= 1'b1;
            if (!we_a) begin
              q_a  <= w_rdata;
              qv_a <= 1'b1;
            end
          end else if (gnt_b) begin
            r_ptr <= 1'b0;
            if (!we_b) begin
              q_b  <= w_rdata;
              qv_b <= 1'b1;
            end
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, compared
// every cycle against a behavioural model of the arbitrated memory.
module tb_ram_rr_arbiter;

  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst, clr_start, req_a, req_b, we_a, we_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_a, data_b;
  logic          gnt_a, gnt_b, qv_a, qv_b, busy;
  logic [DW-1:0] q_a, q_b;

  ram_rr_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start),
    .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
    .addr_a(addr_a), .addr_b(addr_b), .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .q_a(q_a), .q_b(q_b),
    .qv_a(qv_a), .qv_b(qv_b), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: cycles of clearing left, memory image, priority side.
  int unsigned   m_clr_left;
  logic          m_ptr_b;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_q_a, m_q_b;
  logic          m_qv_a, m_qv_b;
  logic          e_ga, e_gb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_grants();
    e_ga = 1'b0;
    e_gb = 1'b0;
    if (!rst && m_clr_left == 0 && !clr_start) begin
      if (req_a && req_b) begin
        e_ga = !m_ptr_b;
        e_gb = m_ptr_b;
      end else begin
        e_ga = req_a;
        e_gb = req_b;
      end
    end
  endtask

  task automatic model_edge();
    m_qv_a = 1'b0;
    m_qv_b = 1'b0;
    if (rst) begin
      m_clr_left = DEPTH;
      m_ptr_b    = 1'b0;
      m_q_a      = '0;
      m_q_b      = '0;
    end else if (m_clr_left > 0) begin
      m_mem[DEPTH - m_clr_left] = '0;
      m_clr_left--;
    end else if (clr_start) begin
      m_clr_left = DEPTH;
    end else if (e_ga) begin
      if (we_a) m_mem[addr_a] = data_a;
      else begin m_q_a = m_mem[addr_a]; m_qv_a = 1'b1; end
      m_ptr_b = 1'b1;
    end else if (e_gb) begin
      if (we_b) m_mem[addr_b] = data_b;
      else begin m_q_b = m_mem[addr_b]; m_qv_b = 1'b1; end
      m_ptr_b = 1'b0;
    end
  endtask

  // Inputs are already applied; check mid-cycle, then advance one edge.
  task automatic step();
    #3;
    model_grants();
    check("gnt_a", {31'd0, gnt_a}, {31'd0, e_ga});
    check("gnt_b", {31'd0, gnt_b}, {31'd0, e_gb});
    check("busy",  {31'd0, busy},  {31'd0, m_clr_left > 0});
    check("qv_a",  {31'd0, qv_a},  {31'd0, m_qv_a});
    check("qv_b",  {31'd0, qv_b},  {31'd0, m_qv_b});
    check("q_a",   {24'd0, q_a},   {24'd0, m_q_a});
    check("q_b",   {24'd0, q_b},   {24'd0, m_q_b});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; clr_start = 1'b0;
    req_a = 1'b0; req_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
  endtask

  task automatic acc_a(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_a = 1'b1; we_a = w; addr_a = a; data_a = d;
  endtask

  task automatic acc_b(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_b = 1'b1; we_b = w; addr_b = a; data_b = d;
  endtask

  // Bounded wait for the end of a clear; returns busy cycles seen.
  task automatic wait_clear(output int unsigned n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    if (busy) check("clear_timeout", 32'd1, 32'd0);
  endtask

  int unsigned nb;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_clr_left = DEPTH; m_ptr_b = 1'b0;
    m_q_a = '0; m_q_b = '0; m_qv_a = 1'b0; m_qv_b = 1'b0;

    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;

    // Post-reset clear length and zeroed contents
    wait_clear(nb);
    check("clear_len_reset", nb, 32'd64);
    acc_a(1'b0, 6'd0, 8'h00);  step();
    acc_a(1'b0, 6'd31, 8'h00); step();
    check("rd0_q", {24'd0, q_a}, 32'h00);
    acc_a(1'b0, 6'd63, 8'h00); step();
    idle(); step();
    check("rd63_q", {24'd0, q_a}, 32'h00);

    // Single-requester write then read
    acc_a(1'b1, 6'd10, 8'h5A); step();
    acc_a(1'b0, 6'd10, 8'h00); step();
    idle(); step();
    check("wr_rd_10", {24'd0, q_a}, 32'h5A);

    // Contention: alternation is checked cycle by cycle by the model
    acc_a(1'b0, 6'd10, 8'h00); acc_b(1'b0, 6'd20, 8'h00);
    repeat (4) step();
    idle(); step();

    // Cross-port coherency
    acc_b(1'b1, 6'd63, 8'hC3); step();
    idle(); acc_a(1'b0, 6'd63, 8'h00); step();
    idle(); step();
    check("coherent_63", {24'd0, q_a}, 32'hC3);

    // Clear preemption with a pending request
    acc_a(1'b0, 6'd10, 8'h00); clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    wait_clear(nb);
    check("clear_len_pre", nb, 32'd64);
    step(); idle(); step();
    check("cleared_10", {24'd0, q_a}, 32'h00);

    // Reset at clear cycle 20 restarts the sweep
    clr_start = 1'b1; step(); clr_start = 1'b0;
    repeat (20) step();
    rst = 1'b1; step(); rst = 1'b0;
    wait_clear(nb);
    check("clear_len_rst", nb, 32'd64);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      idle();
      req_a     = $urandom_range(0, 2) != 0;
      req_b     = $urandom_range(0, 2) != 0;
      we_a      = $urandom_range(0, 1);
      we_b      = $urandom_range(0, 1);
      addr_a    = AW'($urandom_range(0, 7));
      addr_b    = AW'($urandom_range(0, 7));
      data_a    = DW'($urandom);
      data_b    = DW'($urandom);
      clr_start = $urandom_range(0, 99) == 0;
      rst       = $urandom_range(0, 499) == 0;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
RAM_RR_ARBITER -- requirements
Module: ram_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the word width.
REQ-002 Parameter ADDR_W, default 6, SHALL set the address width; depth = 2**ADDR_W words (64 by default).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 clr_start  input  1  SHALL be a pulse requesting a full-memory clear.
REQ-006 req_a / req_b  input  1  SHALL be the access request per requester; held high until granted.
REQ-007 we_a / we_b  input  1  SHALL select write (1) or read (0), valid while req is high.
REQ-008 addr_a / addr_b  input  ADDR_W  SHALL be the access address, valid while req is high.
REQ-009 data_a / data_b  input  DATA_W  SHALL be the write data, valid while req and we are high.
REQ-010 gnt_a / gnt_b  output  1  SHALL be combinational grant; access is performed at the clock edge ending the grant cycle.
REQ-011 q_a / q_b  output  DATA_W  SHALL be registered read data per requester.
REQ-012 qv_a / qv_b  output  1  SHALL be a one-cycle pulse marking q_x valid.
REQ-013 busy  output  1  SHALL be high while the block is in CLEAR.

Function
REQ-014 Internal storage SHALL be one 2**ADDR_W x DATA_W array with at most one access (read or write) per cycle.
REQ-015 FSM SHALL have exactly two states: CLEAR and RUN; busy = (state == CLEAR).
REQ-016 In CLEAR, an ADDR_W-bit counter SHALL write 0 to ram[cnt] each cycle, from 0 up to 2**ADDR_W-1, and SHALL enter RUN on the edge that writes the last address (64 cycles by default).
REQ-017 In CLEAR, gnt_a, gnt_b, qv_a and qv_b SHALL be 0, and clr_start SHALL be ignored without restarting the counter.
REQ-018 In RUN, clr_start = 1 SHALL take priority over all requests: no grant that cycle; next state CLEAR with cnt = 0.
REQ-019 In RUN without clr_start, exactly one requester SHALL be granted if any req is high: a single requester is always granted; with both high, the side indicated by a 1-bit round-robin pointer is granted.
REQ-020 After every grant, the pointer SHALL point to the non-granted side; with no grant, it SHALL hold.
REQ-021 A granted write SHALL update ram[addr_x] <= data_x at the grant edge; qv_x stays 0 and q_x holds.
REQ-022 A granted read SHALL load q_x <= ram[addr_x] at the grant edge and pulse qv_x for the following cycle (latency 1).
REQ-023 A read of an address the other requester writes in the immediately preceding grant SHALL return the new data.
REQ-024 q_x SHALL hold its last value whenever qv_x = 0.
REQ-025 The non-granted requester's q_x and qv_x SHALL be unaffected (qv_x = 0).

Reset
REQ-026 rst = 1 SHALL force state CLEAR, cnt = 0, pointer = A, q_a = q_b = 0, qv_a = qv_b = 0, and gnt_a = gnt_b = 0 while asserted.
REQ-027 rst asserted mid-CLEAR or mid-RUN SHALL restart the clear from address 0; busy = 1 from the first cycle after rst.
REQ-028 Memory contents SHALL be all zero once busy first falls after reset.

Verification
REQ-029 Post-reset clear: release rst, hold all req low -> busy high 64 cycles then low; reads of addr 0, 31 and 63 return 0x00.
REQ-030 Write/read single requester: A writes 0x5A to addr 10, then A reads addr 10 -> gnt_a each cycle, qv_a pulse one cycle after the read grant, q_a = 0x5A.
REQ-031 Contention: req_a and req_b both held high for 4 cycles, reads of different addresses, pointer = A -> grants alternate A, B, A, B; each qv pulse follows its own grant.
REQ-032 Cross-port coherency: B writes 0xC3 to addr 63, A reads addr 63 next cycle -> q_a = 0xC3.
REQ-033 Clear preemption: clr_start pulsed with req_a high in RUN -> no gnt_a that cycle; busy for 64 cycles; then A is granted and reads 0x00 from a previously written address.
REQ-034 Reset mid-clear: assert rst at clear cycle 20 -> busy stays high; the clear restarts from 0; busy falls exactly 64 cycles after rst deasserts.
